fb_port_arbiter: RTL and testbench
==================================

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 The block SHALL have parameter FB_WIDTH, default 640, meaning framebuffer width in pixels.
REQ-002 The block SHALL have parameter FB_HEIGHT, default 480, meaning framebuffer height in pixels.
REQ-003 The block SHALL have parameter WR_STARVE_LIMIT, default 16, meaning the number of consecutive unserved write-pending cycles that triggers the guard.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- blend_read_en  in  1  blend read request; fixed latency, no backpressure.
- blend_read_x / blend_read_y  in  clog2(FB_WIDTH) / clog2(FB_HEIGHT)  blend read pixel.
- blend_read_data  out  16  RGB565 read data.
- blend_read_valid  out  1  blend data strobe.
- scan_req  in  1  scanout read request.
- scan_x / scan_y  in  same widths as the blend coordinates  scanout read pixel.
- scan_gnt  out  1  scanout request accepted this cycle.
- scan_rdata  out  16  scanout data.
- scan_rvalid  out  1  scanout data strobe.
- wr_valid  in  1  pixel write request.
- wr_x / wr_y  in  same widths as the blend coordinates  write pixel.
- wr_data  in  16  RGB565 write data.
- wr_ready  out  1  write accepted this cycle.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  linear address, where ADDR_W = clog2(FB_WIDTH*FB_HEIGHT).
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, returned 2 cycles after the read.
- hold_off  out  1  request to the upstream blend pipeline to suppress blend_read_en.
- proto_err  out  1  sticky protocol-violation flag.

Function
REQ-005 The block SHALL arbitrate one single-port memory access per cycle with fixed priority: blend read, then scanout read, then write.
REQ-006 mem_en, mem_we, mem_addr and mem_wdata SHALL be combinational from the winning request in the same cycle.
- mem_addr = y*FB_WIDTH + x.
- mem_en = 0 when no request is present.
REQ-007 scan_gnt SHALL equal scan_req AND NOT blend_read_en AND NOT force_wr.
REQ-008 wr_ready SHALL equal wr_valid AND NOT blend_read_en AND NOT scan_gnt.
REQ-009 A 2-stage tag shift register SHALL record each read's owner (none/blend/scan).
- Exactly 2 cycles after a granted read, mem_rdata SHALL be presented on the owner's data port.
- The owner's valid strobe SHALL pulse for exactly 1 cycle.
- The non-owner valid strobe SHALL stay 0.
REQ-010 blend_read_data and scan_rdata SHALL be a pass-through of mem_rdata; only the strobes are gated.
REQ-011 Accesses SHALL complete in grant order.
- A write granted in cycle N followed by a read of the same address in cycle N+1 SHALL return the new data.
- This ordering relies on the memory; the arbiter adds no reordering.
REQ-012 Back-to-back reads on consecutive cycles SHALL be supported at full rate, with tags pipelined independently.

Configuration
REQ-013 When the macro FB_ARB_STARVE_GUARD_EN is defined, the write starvation guard SHALL be compiled in, operating as follows:
- A counter SHALL increment each cycle wr_valid=1 and wr_ready=0, and clear on any cycle with wr_ready=1 or wr_valid=0.
- The counter SHALL saturate at WR_STARVE_LIMIT.
- On reaching WR_STARVE_LIMIT, registered hold_off and internal force_wr SHALL assert from the next cycle.
- force_wr SHALL mask scan_gnt.
- Both SHALL deassert the cycle after a write is accepted.
- If blend_read_en=1 while hold_off=1, the blend read SHALL still win, and proto_err SHALL set and remain set until reset.
REQ-014 When FB_ARB_STARVE_GUARD_EN is not defined:
- hold_off, force_wr and proto_err SHALL be constant 0.
- No counter SHALL exist.

Reset
REQ-015 While rst=1, the block SHALL hold the following values:
- blend_read_valid=0 and scan_rvalid=0.
- Both tag stages = none.
- hold_off=0 and proto_err=0.
- Starve counter = 0.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight tags, so no valid strobe fires for reads granted before reset.
REQ-017 Combinational outputs (mem_*, scan_gnt, wr_ready) SHALL follow their REQ-006..008 equations during reset, with force_wr=0.

Verification
REQ-018 The bench SHALL drive blend_read_en, scan_req and wr_valid together in cycle N (blend x=3, y=2) and check the following:
- mem_addr=1283 and mem_we=0 in cycle N.
- scan_gnt=0 and wr_ready=0 in cycle N.
- blend_read_valid=1 in cycle N+2.
REQ-019 The bench SHALL drive scan_req and wr_valid (no blend) and check:
- scan_gnt=1 and wr_ready=0.
- scan_rvalid=1 exactly 2 cycles later with scan_rdata=mem_rdata.
REQ-020 The bench SHALL alternate blend and scan reads each cycle for 8 cycles and check that the strobes alternate with a 2-cycle offset and no cross-routing.
REQ-021 The bench SHALL write 0xF800 to (10,10) in cycle N, blend-read (10,10) in cycle N+1, and check blend_read_data=0xF800 in cycle N+3.
REQ-022 With FB_ARB_STARVE_GUARD_EN defined, the bench SHALL hold scan_req=1 and wr_valid=1 for 20 cycles and check:
- hold_off=1 at cycle 17.
- wr_ready=1 at cycle 17.
- hold_off=0 at cycle 18.
REQ-023 The bench SHALL issue a blend read and assert rst the following cycle, and check that blend_read_valid stays 0 and all outputs match REQ-015.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// -----------------------------------------------------------------------------
// fb_port_arbiter
//
// Shares one single-port framebuffer memory between three clients, one access
// per cycle, with fixed priority: blend read > scanout read > pixel write.
// The memory returns read data two cycles after the read. A two-stage owner
// tag pipeline steers each returning word to the blend or the scanout strobe.
//
// Optional feature (macro FB_ARB_STARVE_GUARD_EN):
//   Write starvation guard. After WR_STARVE_LIMIT consecutive cycles of a
//   pending but unserved write, hold_off is raised to the blend pipeline and
//   scanout grants are masked until one write is accepted. A blend read that
//   arrives while hold_off is high still wins and sets the sticky proto_err.
//   Without the macro, hold_off and proto_err are tied low and no counter
//   exists.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   blend_read_en/_x/_y           blend read request (no backpressure)
//   blend_read_data/_valid        blend read data and one-cycle strobe
//   scan_req/_x/_y, scan_gnt      scanout read request and same-cycle grant
//   scan_rdata/_rvalid            scanout read data and one-cycle strobe
//   wr_valid/_x/_y/_data          pixel write request, wr_ready = accepted
//   mem_en/_we/_addr/_wdata       memory access, combinational from winner
//   mem_rdata                     memory read data, 2 cycles after the read
//   hold_off                      ask the blend pipeline to stop issuing
//   proto_err                     sticky: blend read issued during hold_off
// -----------------------------------------------------------------------------
module fb_port_arbiter #(
    parameter int FB_WIDTH        = 640,
    parameter int FB_HEIGHT       = 480,
    parameter int WR_STARVE_LIMIT = 16,
    localparam int XW     = $clog2(FB_WIDTH),
    localparam int YW     = $clog2(FB_HEIGHT),
    localparam int ADDR_W = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blend_read_en,
    input  logic [XW-1:0]     blend_read_x,
    input  logic [YW-1:0]     blend_read_y,
    output logic [15:0]       blend_read_data,
    output logic              blend_read_valid,
    input  logic              scan_req,
    input  logic [XW-1:0]     scan_x,
    input  logic [YW-1:0]     scan_y,
    output logic              scan_gnt,
    output logic [15:0]       scan_rdata,
    output logic              scan_rvalid,
    input  logic              wr_valid,
    input  logic [XW-1:0]     wr_x,
    input  logic [YW-1:0]     wr_y,
    input  logic [15:0]       wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              hold_off,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_BLEND = 2'd1,
        TAG_SCAN  = 2'd2
    } tag_t;

    logic force_wr;
    tag_t tag_d;
    tag_t tag_s1;
    tag_t tag_s2;

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [YW-1:0] y,
                                                   input logic [XW-1:0] x);
        return ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
    endfunction

    // ------------------------------------------------------------------
    // Grants. Blend never waits; force_wr only blocks scanout.
    // ------------------------------------------------------------------
    assign scan_gnt = scan_req & ~blend_read_en & ~force_wr;
    assign wr_ready = wr_valid & ~blend_read_en & ~scan_gnt;

    // NOTE: every output of this block gets a default before the priority
    // chain, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_d     = TAG_NONE;
        if (blend_read_en) begin
            mem_en   = 1'b1;
            mem_addr = lin_addr(blend_read_y, blend_read_x);
            tag_d    = TAG_BLEND;
        end else if (scan_gnt) begin
            mem_en   = 1'b1;
            mem_addr = lin_addr(scan_y, scan_x);
            tag_d    = TAG_SCAN;
        end else if (wr_ready) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = lin_addr(wr_y, wr_x);
            mem_wdata = wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Owner tags follow the memory's 2-cycle read latency. Reset clears
    // both stages so reads in flight at reset never raise a strobe.
    // ------------------------------------------------------------------
    // NOTE: registers use non-blocking assignment so tag_s2 takes the old
    // tag_s1 on the same edge, giving a true two-stage shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_s1 <= TAG_NONE;
            tag_s2 <= TAG_NONE;
        end else begin
            tag_s1 <= tag_d;
            tag_s2 <= tag_s1;
        end
    end

    // Data is a straight pass-through; only the strobes are steered.
    assign blend_read_data  = mem_rdata;
    assign scan_rdata       = mem_rdata;
    assign blend_read_valid = (tag_s2 == TAG_BLEND);
    assign scan_rvalid      = (tag_s2 == TAG_SCAN);

`ifdef FB_ARB_STARVE_GUARD_EN
    // ------------------------------------------------------------------
    // Write starvation guard.
    // ------------------------------------------------------------------
    localparam int CNT_W = $clog2(WR_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WR_STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             hold_q;
    logic             err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            hold_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (!wr_valid || wr_ready) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            // Raised the cycle after the counter sits at the limit; dropped
            // the cycle after the write it was protecting gets through.
            if (wr_ready) begin
                hold_q <= 1'b0;
            end else if (wr_valid && starve_cnt == CNT_MAX) begin
                hold_q <= 1'b1;
            end

            if (blend_read_en && hold_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign force_wr  = hold_q;
    assign hold_off  = hold_q;
    assign proto_err = err_q;
`else
    assign force_wr  = 1'b0;
    assign hold_off  = 1'b0;
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_port_arbiter
//
// Self-checking bench for fb_port_arbiter. A behavioural single-port memory
// with 2-cycle read latency is preloaded with an address-derived pattern.
// Combinational outputs are compared from a vector table and from short
// hand-written sequences; every granted read pushes its expected owner and
// data to a scoreboard that is compared on the cycle the strobe is due.
// Build with +define+FB_ARB_STARVE_GUARD_EN to exercise the starvation guard.
// -----------------------------------------------------------------------------
module tb_fb_port_arbiter;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int XW        = $clog2(FB_WIDTH);
    localparam int YW        = $clog2(FB_HEIGHT);
    localparam int ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT);
    localparam int MEM_WORDS = FB_WIDTH * FB_HEIGHT;

    logic              clk = 1'b0;
    logic              rst;
    logic              blend_read_en;
    logic [XW-1:0]     blend_read_x;
    logic [YW-1:0]     blend_read_y;
    logic [15:0]       blend_read_data;
    logic              blend_read_valid;
    logic              scan_req;
    logic [XW-1:0]     scan_x;
    logic [YW-1:0]     scan_y;
    logic              scan_gnt;
    logic [15:0]       scan_rdata;
    logic              scan_rvalid;
    logic              wr_valid;
    logic [XW-1:0]     wr_x;
    logic [YW-1:0]     wr_y;
    logic [15:0]       wr_data;
    logic              wr_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              hold_off;
    logic              proto_err;

    fb_port_arbiter #(
        .FB_WIDTH       (FB_WIDTH),
        .FB_HEIGHT      (FB_HEIGHT),
        .WR_STARVE_LIMIT(16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .blend_read_en   (blend_read_en),
        .blend_read_x    (blend_read_x),
        .blend_read_y    (blend_read_y),
        .blend_read_data (blend_read_data),
        .blend_read_valid(blend_read_valid),
        .scan_req        (scan_req),
        .scan_x          (scan_x),
        .scan_y          (scan_y),
        .scan_gnt        (scan_gnt),
        .scan_rdata      (scan_rdata),
        .scan_rvalid     (scan_rvalid),
        .wr_valid        (wr_valid),
        .wr_x            (wr_x),
        .wr_y            (wr_y),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .hold_off        (hold_off),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural memory: write at the edge, read data after two edges.
    // ------------------------------------------------------------------
    logic [15:0] fb_mem [0:MEM_WORDS-1];
    logic [15:0] rd_pipe0;
    logic [15:0] rd_pipe1;

    always @(posedge clk) begin
        if (mem_en && mem_we) fb_mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) rd_pipe0 <= fb_mem[mem_addr];
        else                   rd_pipe0 <= 16'h0000;
        rd_pipe1 <= rd_pipe0;
    end
    assign mem_rdata = rd_pipe1;

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic        blend;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t     sb[$];
    logic [15:0] shadow[int];

    function automatic logic [15:0] pattern(input int a);
        return 16'(a) ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] exp_data(input int a);
        if (shadow.exists(a)) return shadow[a];
        return pattern(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_read(input logic is_blend, input int addr);
        rd_exp_t e;
        e.due   = cyc + 2;
        e.blend = is_blend;
        e.data  = exp_data(addr);
        sb.push_back(e);
    endtask

    // Compare the read strobes for the current cycle against the scoreboard.
    task automatic sb_check();
        rd_exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("blend_read_valid", {31'd0, blend_read_valid}, {31'd0, e.blend});
            check("scan_rvalid", {31'd0, scan_rvalid}, {31'd0, !e.blend});
            if (e.blend) check("blend_read_data", {16'd0, blend_read_data}, {16'd0, e.data});
            else         check("scan_rdata", {16'd0, scan_rdata}, {16'd0, e.data});
        end else begin
            check("blend_valid_idle", {31'd0, blend_read_valid}, 32'd0);
            check("scan_valid_idle", {31'd0, scan_rvalid}, 32'd0);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        sb_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        blend_read_en = 1'b0; blend_read_x = '0; blend_read_y = '0;
        scan_req      = 1'b0; scan_x       = '0; scan_y       = '0;
        wr_valid      = 1'b0; wr_x         = '0; wr_y         = '0;
        wr_data       = '0;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table: one cycle each, all three requesters
    // ------------------------------------------------------------------
    typedef struct {
        logic        be, sr, wv;
        int          bx, by, sx, sy, wx, wy;
        logic [15:0] wd;
        logic        e_en, e_we;
        int          e_addr;
        logic        e_gnt, e_rdy;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    initial begin
        // Contention among all three: blend (3,2) wins.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 3, 2, 5, 1, 7, 0, 16'h1234, 1'b1, 1'b0, 1283, 1'b0, 1'b0};
        // Scan beats write.
        vecs[1] = '{1'b0, 1'b1, 1'b1, 0, 0, 5, 1, 7, 0, 16'h1234, 1'b1, 1'b0, 645, 1'b1, 1'b0};
        // Lone write.
        vecs[2] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 7, 0, 16'h07E0, 1'b1, 1'b1, 7, 1'b0, 1'b1};
        // Nothing requested.
        vecs[3] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        // Last pixel of the frame.
        vecs[4] = '{1'b1, 1'b0, 1'b0, 639, 479, 0, 0, 0, 0, 16'h0000, 1'b1, 1'b0, 307199, 1'b0, 1'b0};
        // Scan of the first pixel of the last row.
        vecs[5] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 479, 0, 0, 16'h0000, 1'b1, 1'b0, 306560, 1'b1, 1'b0};
        // Blend beats write.
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 8, 0, 16'hBEEF, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        // Blend beats scan.
        vecs[7] = '{1'b1, 1'b1, 1'b0, 0, 1, 2, 2, 0, 0, 16'h0000, 1'b1, 1'b0, 640, 1'b0, 1'b0};

        for (int a = 0; a < MEM_WORDS; a++) fb_mem[a] = pattern(a);

        // ---------------- reset state ----------------
        idle();
        rst = 1'b1;
        sample();
        check("rst_hold_off", {31'd0, hold_off}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_mem_en_idle", {31'd0, mem_en}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            blend_read_en = vecs[i].be;
            blend_read_x  = XW'(vecs[i].bx);
            blend_read_y  = YW'(vecs[i].by);
            scan_req      = vecs[i].sr;
            scan_x        = XW'(vecs[i].sx);
            scan_y        = YW'(vecs[i].sy);
            wr_valid      = vecs[i].wv;
            wr_x          = XW'(vecs[i].wx);
            wr_y          = YW'(vecs[i].wy);
            wr_data       = vecs[i].wd;
            sample();
            check($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].e_en});
            check($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            check($sformatf("v%0d_scan_gnt", i), {31'd0, scan_gnt}, {31'd0, vecs[i].e_gnt});
            check($sformatf("v%0d_wr_ready", i), {31'd0, wr_ready}, {31'd0, vecs[i].e_rdy});
            if (vecs[i].e_en)
                check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), vecs[i].e_addr);
            if (vecs[i].e_we) begin
                check($sformatf("v%0d_mem_wdata", i), {16'd0, mem_wdata}, {16'd0, vecs[i].wd});
                shadow[vecs[i].e_addr] = vecs[i].wd;
            end
            if (vecs[i].e_en && !vecs[i].e_we) push_read(vecs[i].be, vecs[i].e_addr);
            advance();
        end
        drain(3);

        // ---------------- alternate blend / scan, 8 cycles ----------------
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i % 2 == 0) begin
                blend_read_en = 1'b1;
                blend_read_x  = XW'(i);
                blend_read_y  = YW'(1);
            end else begin
                scan_req = 1'b1;
                scan_x   = XW'(i + 20);
                scan_y   = YW'(3);
            end
            sample();
            check("alt_scan_gnt", {31'd0, scan_gnt}, {31'd0, (i % 2 == 1)});
            if (i % 2 == 0) push_read(1'b1, 1 * FB_WIDTH + i);
            else            push_read(1'b0, 3 * FB_WIDTH + i + 20);
            advance();
        end
        drain(3);

        // ---------------- write then read-after-write ----------------
        idle();
        wr_valid = 1'b1; wr_x = XW'(10); wr_y = YW'(10); wr_data = 16'hF800;
        sample();
        check("raw_wr_ready", {31'd0, wr_ready}, 32'd1);
        shadow[10 * FB_WIDTH + 10] = 16'hF800;
        advance();
        idle();
        blend_read_en = 1'b1; blend_read_x = XW'(10); blend_read_y = YW'(10);
        sample();
        check("raw_mem_addr", 32'(mem_addr), 32'd6410);
        push_read(1'b1, 10 * FB_WIDTH + 10);
        advance();
        drain(3);

        // ---------------- sustained scan + write, 20 cycles ----------------
        for (int k = 0; k < 20; k++) begin
            logic e_hold, e_rdy, e_gnt;
`ifdef FB_ARB_STARVE_GUARD_EN
            e_hold = (k == 17);
`else
            e_hold = 1'b0;
`endif
            e_rdy = e_hold;
            e_gnt = !e_hold;
            idle();
            scan_req = 1'b1; scan_x = XW'(k); scan_y = YW'(5);
            wr_valid = 1'b1; wr_x = XW'(20); wr_y = YW'(20); wr_data = 16'h001F;
            sample();
            check($sformatf("starve_k%0d_hold_off", k), {31'd0, hold_off}, {31'd0, e_hold});
            check($sformatf("starve_k%0d_wr_ready", k), {31'd0, wr_ready}, {31'd0, e_rdy});
            check($sformatf("starve_k%0d_scan_gnt", k), {31'd0, scan_gnt}, {31'd0, e_gnt});
            if (e_gnt) push_read(1'b0, 5 * FB_WIDTH + k);
            if (e_rdy) shadow[20 * FB_WIDTH + 20] = 16'h001F;
            advance();
        end
        drain(3);

`ifdef FB_ARB_STARVE_GUARD_EN
        // ---------------- blend read during hold_off ----------------
        for (int k = 0; k < 19; k++) begin
            idle();
            scan_req = 1'b1; scan_x = XW'(k); scan_y = YW'(6);
            wr_valid = 1'b1; wr_x = XW'(21); wr_y = YW'(20); wr_data = 16'h0ABC;
            if (k == 17) begin
                blend_read_en = 1'b1; blend_read_x = XW'(4); blend_read_y = YW'(4);
            end
            sample();
            if (k < 17) begin
                push_read(1'b0, 6 * FB_WIDTH + k);
            end else if (k == 17) begin
                check("err_hold_off", {31'd0, hold_off}, 32'd1);
                check("err_blend_wins_we", {31'd0, mem_we}, 32'd0);
                check("err_blend_wins_rdy", {31'd0, wr_ready}, 32'd0);
                check("err_proto_before", {31'd0, proto_err}, 32'd0);
                push_read(1'b1, 4 * FB_WIDTH + 4);
            end else begin
                check("err_proto_set", {31'd0, proto_err}, 32'd1);
                check("err_wr_after", {31'd0, wr_ready}, 32'd1);
                shadow[20 * FB_WIDTH + 21] = 16'h0ABC;
            end
            advance();
        end
        drain(3);
        check("err_proto_sticky", {31'd0, proto_err}, 32'd1);
        check("err_hold_cleared", {31'd0, hold_off}, 32'd0);
`endif

        // ---------------- reset with a read in flight ----------------
        idle();
        blend_read_en = 1'b1; blend_read_x = XW'(9); blend_read_y = YW'(9);
        sample();
        advance();
        idle();
        rst = 1'b1;
        scan_req = 1'b1; scan_x = XW'(1); scan_y = YW'(1);
        wr_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("inrst_scan_gnt", {31'd0, scan_gnt}, 32'd1);
            check("inrst_wr_ready", {31'd0, wr_ready}, 32'd0);
            check("inrst_mem_addr", 32'(mem_addr), 32'd641);
            check("inrst_hold_off", {31'd0, hold_off}, 32'd0);
            check("inrst_proto_err", {31'd0, proto_err}, 32'd0);
            advance();
        end
        rst = 1'b0;
        drain(3);

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
